dkongjr_snd_feeder: RTL

- Writer-side front end for the sound DAC path.
- Captures sound-CPU writes to the DAC port and to the decay-control bit.
- Buffers samples in a small FIFO and releases them to the DAC decay/attenuator stage at a fixed sample tick.
- Drives that stage's 8-bit offset-binary sample input and its decay-enable input. On data underrun it mutes cleanly to midscale.

---
 rtl/dkongjr_snd_feeder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dkongjr_snd_feeder.sv
// dkongjr_snd_feeder: sound-CPU DAC writes -> FIFO -> sample-tick release.
// Optional DKJR_SND_RAMP_EN: underrun mute ramps one LSB per tick to 0x80.
module dkongjr_snd_feeder #(
  parameter int SAMPLE_CNT = 1114,
  parameter int FIFO_AW    = 3,
  parameter int HOLD_TICKS = 64
) (
  input  logic       I_CLK,
  input  logic       I_RESET_n,
  input  logic       I_SMP_WR,
  input  logic [7:0] I_SMP_DAT,
  input  logic       I_CTL_WR,
  input  logic       I_CTL_DAT,
  input  logic       I_OVF_CLR,
  output logic [7:0] O_SND_DAT,
  output logic       O_DECAY_EN,
  output logic       O_FULL,
  output logic       O_EMPTY,
  output logic       O_OVF
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int TCW   = $clog2(SAMPLE_CNT);
  localparam int HCW   = $clog2(HOLD_TICKS + 1);
  localparam logic [7:0] MID = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    MUTE
  } state_t;

  state_t state, state_nxt;

  logic [TCW-1:0]     tcnt;
  logic               tick;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               full_i, have, pop, push;
  logic               ovf_set;
  logic [7:0]         snd_nxt;
  logic [HCW-1:0]     hold, hold_nxt;
  logic               ctl_req, req_nxt;

  assign tick    = (tcnt == TCW'(SAMPLE_CNT - 1));
  assign full_i  = (cnt == CW'(DEPTH));
  assign have    = (cnt != '0);
  assign pop     = tick & have;
  assign push    = I_SMP_WR & (~full_i | pop);
  assign ovf_set = I_SMP_WR & full_i & ~pop;
  assign req_nxt = I_CTL_WR ? I_CTL_DAT : ctl_req;

  // Free-running sample tick divider.
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care once pointers reset.
  always_ff @(posedge I_CLK) begin
    if (push) begin
      mem[wr_ptr] <= I_SMP_DAT;
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // FIFO pointers, occupancy, flags and sticky overflow.
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      O_FULL  <= 1'b0;
      O_EMPTY <= 1'b1;
      O_OVF   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt     <= cnt_nxt;
      O_FULL  <= (cnt_nxt == CW'(DEPTH));
      O_EMPTY <= (cnt_nxt == '0);
      O_OVF   <= ovf_set | (O_OVF & ~I_OVF_CLR);
    end
  end

  // Playback FSM: next state, next sample, hold count.
  always_comb begin
    state_nxt = state;
    snd_nxt   = O_SND_DAT;
    hold_nxt  = hold;
    if (tick) begin
      if (have) begin
        state_nxt = RUN;
        snd_nxt   = mem[rd_ptr];
        hold_nxt  = '0;
      end else begin
        unique case (state)
          IDLE: begin
            snd_nxt = MID;
          end
          RUN: begin
            state_nxt = HOLD;
            hold_nxt  = HCW'(1);
          end
          HOLD: begin
            hold_nxt = hold + 1'b1;
            if (hold_nxt == HCW'(HOLD_TICKS)) begin
              state_nxt = MUTE;
            end
          end
          MUTE: begin
`ifdef DKJR_SND_RAMP_EN
            if (O_SND_DAT > MID) begin
              snd_nxt = O_SND_DAT - 8'd1;
            end else if (O_SND_DAT < MID) begin
              snd_nxt = O_SND_DAT + 8'd1;
            end
            if (snd_nxt == MID) begin
              state_nxt = IDLE;
            end
`else
            snd_nxt   = MID;
            state_nxt = IDLE;
`endif
          end
        endcase
      end
    end
  end

  // FSM registers, sample output and decay enable.
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      state      <= IDLE;
      hold       <= '0;
      O_SND_DAT  <= MID;
      ctl_req    <= 1'b0;
      O_DECAY_EN <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      O_SND_DAT  <= snd_nxt;
      ctl_req    <= req_nxt;
      O_DECAY_EN <= req_nxt & (state_nxt != IDLE);
    end
  end

endmodule
